// File: rtl/exu_decode_stage_if.sv
// exu_decode_stage_if
//   Handshake bundle between the IFU, the decode stage and EXU dispatch.
//   master : upstream/downstream environment (drives i_*, flush, o_ready)
//   slave  : the decode stage (drives i_ready and all decoded o_* fields)
//   flush          : drop buffered and incoming instructions
//   i_valid/i_ready: fetch handshake; i_instr, i_pc, fetch sideband
//   o_valid/o_ready: dispatch handshake; decoded fields of the head entry
interface exu_decode_stage_if #(
   parameter int XLEN        = 32,
   parameter int PC_SIZE     = 32,
   parameter int RFIDX_WIDTH = 5
);
   logic                   flush;
   logic                   i_valid;
   logic                   i_ready;
   logic [31:0]            i_instr;
   logic [PC_SIZE-1:0]     i_pc;
   logic                   i_misalgn;
   logic                   i_buserr;
   logic                   i_prdt_taken;
   logic                   o_valid;
   logic                   o_ready;
   logic [RFIDX_WIDTH-1:0] o_rs1idx;
   logic [RFIDX_WIDTH-1:0] o_rs2idx;
   logic [RFIDX_WIDTH-1:0] o_rdidx;
   logic                   o_rs1en;
   logic                   o_rs2en;
   logic                   o_rdwen;
   logic                   o_rs1x0;
   logic                   o_rs2x0;
   logic [XLEN-1:0]        o_imm;
   logic [PC_SIZE-1:0]     o_pc;
   logic [5:0]             o_class;
   logic [2:0]             o_func3;
   logic [6:0]             o_func7;
   logic                   o_misalgn;
   logic                   o_buserr;
   logic                   o_prdt_taken;

   modport master (
      output flush, i_valid, i_instr, i_pc, i_misalgn, i_buserr, i_prdt_taken, o_ready,
      input  i_ready, o_valid, o_rs1idx, o_rs2idx, o_rdidx, o_rs1en, o_rs2en, o_rdwen,
             o_rs1x0, o_rs2x0, o_imm, o_pc, o_class, o_func3, o_func7,
             o_misalgn, o_buserr, o_prdt_taken
   );

   modport slave (
      input  flush, i_valid, i_instr, i_pc, i_misalgn, i_buserr, i_prdt_taken, o_ready,
      output i_ready, o_valid, o_rs1idx, o_rs2idx, o_rdidx, o_rs1en, o_rs2en, o_rdwen,
             o_rs1x0, o_rs2x0, o_imm, o_pc, o_class, o_func3, o_func7,
             o_misalgn, o_buserr, o_prdt_taken
   );
endinterface

// File: rtl/exu_decode_stage.sv
// exu_decode_stage
//   RV32 decode stage: combinational decode of the fetched word, results
//   stored in a 2-entry skid FIFO, head entry drives the dispatch outputs.
//   Ports: clk, rst (synchronous, active high), bus (exu_decode_stage_if.slave)
//   Build option: define EXU_DEC_MULDIV_EN to decode OP/func7=0000001 as
//   muldiv; otherwise that encoding is illegal and o_class[4] stays 0.
//   o_class one-hot: {csr, muldiv, lsu, bjp, alu, ilegl}
module exu_decode_stage #(
   parameter int XLEN        = 32,
   parameter int PC_SIZE     = 32,
   parameter int RFIDX_WIDTH = 5
) (
   input logic                clk,
   input logic                rst,
   exu_decode_stage_if.slave  bus
);

`ifdef EXU_DEC_MULDIV_EN
   localparam bit MULDIV_EN = 1'b1;
`else
   localparam bit MULDIV_EN = 1'b0;
`endif

   localparam int CLS_ILEGL  = 0;
   localparam int CLS_ALU    = 1;
   localparam int CLS_BJP    = 2;
   localparam int CLS_LSU    = 3;
   localparam int CLS_MULDIV = 4;
   localparam int CLS_CSR    = 5;

   typedef struct packed {
      logic [RFIDX_WIDTH-1:0] rs1idx;
      logic [RFIDX_WIDTH-1:0] rs2idx;
      logic [RFIDX_WIDTH-1:0] rdidx;
      logic                   rs1en;
      logic                   rs2en;
      logic                   rdwen;
      logic [XLEN-1:0]        imm;
      logic [PC_SIZE-1:0]     pc;
      logic [5:0]             cls;
      logic [2:0]             func3;
      logic [6:0]             func7;
      logic                   misalgn;
      logic                   buserr;
      logic                   prdt_taken;
   } dec_t;

   logic [31:0]     ins;
   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic            legal;
   dec_t            dec;
   dec_t            head;
   dec_t            mem [2];
   logic [1:0]      count;
   logic            wr_ptr, rd_ptr;
   logic            push, pop;

   assign ins    = bus.i_instr;
   assign opcode = ins[6:0];
   assign f3     = ins[14:12];
   assign f7     = ins[31:25];

   // signed casts give the sign extension to XLEN for free
   assign imm_i = XLEN'($signed(ins[31:20]));
   assign imm_s = XLEN'($signed({ins[31:25], ins[11:7]}));
   assign imm_b = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({ins[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

   always_comb begin
      dec            = '0;
      legal          = 1'b1;
      dec.rs1idx     = RFIDX_WIDTH'(ins[19:15]);
      dec.rs2idx     = RFIDX_WIDTH'(ins[24:20]);
      dec.rdidx      = RFIDX_WIDTH'(ins[11:7]);
      dec.func3      = f3;
      dec.func7      = f7;
      dec.pc         = bus.i_pc;
      dec.misalgn    = bus.i_misalgn;
      dec.buserr     = bus.i_buserr;
      dec.prdt_taken = bus.i_prdt_taken;
      case (opcode)
         7'b0110111, 7'b0010111: begin
            dec.cls[CLS_ALU] = 1'b1; dec.imm = imm_u; dec.rdwen = 1'b1;
         end
         7'b1101111: begin
            dec.cls[CLS_BJP] = 1'b1; dec.imm = imm_j; dec.rdwen = 1'b1;
         end
         7'b1100111: begin
            legal = (f3 == 3'b000);
            dec.cls[CLS_BJP] = 1'b1; dec.imm = imm_i; dec.rs1en = 1'b1; dec.rdwen = 1'b1;
         end
         7'b1100011: begin
            legal = (f3[2:1] != 2'b01);
            dec.cls[CLS_BJP] = 1'b1; dec.imm = imm_b; dec.rs1en = 1'b1; dec.rs2en = 1'b1;
         end
         7'b0000011: begin
            legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            dec.cls[CLS_LSU] = 1'b1; dec.imm = imm_i; dec.rs1en = 1'b1; dec.rdwen = 1'b1;
         end
         7'b0100011: begin
            legal = (f3[2] == 1'b0) && (f3 != 3'b011);
            dec.cls[CLS_LSU] = 1'b1; dec.imm = imm_s; dec.rs1en = 1'b1; dec.rs2en = 1'b1;
         end
         7'b0010011: begin
            // only the shift encodings constrain func7
            if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
            else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
            dec.cls[CLS_ALU] = 1'b1; dec.imm = imm_i; dec.rs1en = 1'b1; dec.rdwen = 1'b1;
         end
         7'b0110011: begin
            dec.rs1en = 1'b1; dec.rs2en = 1'b1; dec.rdwen = 1'b1;
            if ((f7 == 7'b0000000) || ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))))
               dec.cls[CLS_ALU] = 1'b1;
            else if ((f7 == 7'b0000001) && MULDIV_EN)
               dec.cls[CLS_MULDIV] = 1'b1;
            else
               legal = 1'b0;
         end
         7'b1110011: begin
            dec.cls[CLS_CSR] = 1'b1; dec.imm = imm_i; dec.rs1en = 1'b1; dec.rdwen = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (!legal) begin
         dec.cls            = '0;
         dec.cls[CLS_ILEGL] = 1'b1;
         dec.imm            = '0;
         dec.rs1en          = 1'b0;
         dec.rs2en          = 1'b0;
         dec.rdwen          = 1'b0;
      end
      // a faulted fetch carries a meaningless word: its fault wins over ilegl
      if (bus.i_misalgn || bus.i_buserr) dec.cls[CLS_ILEGL] = 1'b0;
      if (dec.rdidx == '0) dec.rdwen = 1'b0;
   end

   assign bus.i_ready = ~rst & (count != 2'd2);
   assign bus.o_valid = (count != 2'd0);
   assign push        = bus.i_valid & bus.i_ready;
   assign pop         = bus.o_valid & bus.o_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         mem[0] <= '0;
         mem[1] <= '0;
      end else if (bus.flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head             = mem[rd_ptr];
   assign bus.o_rs1idx     = head.rs1idx;
   assign bus.o_rs2idx     = head.rs2idx;
   assign bus.o_rdidx      = head.rdidx;
   assign bus.o_rs1en      = head.rs1en;
   assign bus.o_rs2en      = head.rs2en;
   assign bus.o_rdwen      = head.rdwen;
   assign bus.o_rs1x0      = (head.rs1idx == '0);
   assign bus.o_rs2x0      = (head.rs2idx == '0);
   assign bus.o_imm        = head.imm;
   assign bus.o_pc         = head.pc;
   assign bus.o_class      = head.cls;
   assign bus.o_func3      = head.func3;
   assign bus.o_func7      = head.func7;
   assign bus.o_misalgn    = head.misalgn;
   assign bus.o_buserr     = head.buserr;
   assign bus.o_prdt_taken = head.prdt_taken;

endmodule
